// File: rtl/ecualizador_mezcla_if.sv
// Band-sample, gain-programming and mixed-output bus of the equalizer mixer.
// The peak signal is only driven with a live value when ECUALIZADOR_PEAK_METER_EN is defined.
interface ecualizador_mezcla_if #(
  parameter int unsigned Width = 25
);
  logic                    enable;
  logic signed [Width-1:0] ykbajos;
  logic signed [Width-1:0] ykmedios;
  logic signed [Width-1:0] ykaltos;
  logic                    gain_we;
  logic [1:0]              gain_sel;
  logic signed [Width-1:0] gain_data;
  logic signed [Width-1:0] yk;
  logic                    yk_valid;
  logic                    busy;
  logic                    sat;
  logic                    drop;
  logic [Width-2:0]        peak;

  // Producer of samples and gains, consumer of the mixed output
  modport master (
    output enable, ykbajos, ykmedios, ykaltos, gain_we, gain_sel, gain_data,
    input  yk, yk_valid, busy, sat, drop, peak
  );

  // The mixer itself
  modport slave (
    input  enable, ykbajos, ykmedios, ykaltos, gain_we, gain_sel, gain_data,
    output yk, yk_valid, busy, sat, drop, peak
  );
endinterface

// File: rtl/ecualizador_mezcla.sv
// Three-band gain/mix stage: one shared multiplier walks low, mid and high
// bands through a Width+2 accumulator, then saturates into yk.
// Optional output peak meter: define ECUALIZADOR_PEAK_METER_EN.
module ecualizador_mezcla #(
  parameter int unsigned Width     = 25,
  parameter int unsigned Presicion = 16,
  parameter int unsigned Magnitud  = Width - Presicion - 1,
  parameter int unsigned DecayLog  = 10
) (
  input logic                 clock44k,
  input logic                 reset,
  ecualizador_mezcla_if.slave bus
);

  localparam int unsigned AccW  = Magnitud + Presicion + 3;
  localparam int unsigned ProdW = 2 * Width;

  localparam logic signed [Width-1:0] GainUnity = Width'(64'sd1 << Presicion);
  localparam logic signed [Width-1:0] OutMax    = Width'((64'sd1 << (Width - 1)) - 64'sd1);
  localparam logic signed [Width-1:0] OutMin    = Width'(-(64'sd1 << (Width - 1)));
  localparam logic signed [AccW-1:0]  AccMax    = AccW'((64'sd1 << (Width - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0]  AccMin    = AccW'(-(64'sd1 << (Width - 1)));

  // Reject parameter sets whose integer/fraction split does not add up
  if (Width != Magnitud + Presicion + 1 || DecayLog == 0) begin : g_param_check
    $error("ecualizador_mezcla: inconsistent Width/Presicion/Magnitud/DecayLog");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_B = 3'd1,
    S_MUL_M = 3'd2,
    S_MUL_A = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_capture;
  logic                    w_acc_en;
  logic                    w_out_en;
  logic                    w_drop;
  logic [1:0]              w_band;

  logic signed [Width-1:0] r_xb, r_xm, r_xa;
  logic signed [Width-1:0] r_gsh  [3];
  logic signed [Width-1:0] r_gact [3];
  logic signed [AccW-1:0]  r_acc;
  logic signed [Width-1:0] w_mul_x, w_mul_g;
  logic signed [ProdW-1:0] w_prod;
  logic signed [AccW-1:0]  w_term;
  logic signed [Width-1:0] w_sat_val;
  logic                    w_clip;

  logic signed [Width-1:0] r_yk;
  logic                    r_yk_valid, r_sat, r_drop, r_busy;

  // State register
  always_ff @(posedge clock44k or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: fixed walk through the three bands once a sample is taken
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.enable) w_next = S_MUL_B;
      S_MUL_B: w_next = S_MUL_M;
      S_MUL_M: w_next = S_MUL_A;
      S_MUL_A: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control decode: capture, band select, accumulate, output and drop strobes
  always_comb begin
    w_capture = 1'b0;
    w_acc_en  = 1'b0;
    w_out_en  = 1'b0;
    w_band    = 2'd0;
    w_drop    = bus.enable && (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:  w_capture = bus.enable;
      S_MUL_B: begin w_acc_en = 1'b1; w_band = 2'd0; end
      S_MUL_M: begin w_acc_en = 1'b1; w_band = 2'd1; end
      S_MUL_A: begin w_acc_en = 1'b1; w_band = 2'd2; end
      S_OUT:   w_out_en = 1'b1;
      default: ;
    endcase
  end

  // Operand mux into the single shared multiplier
  always_comb begin
    w_mul_x = r_xb;
    w_mul_g = r_gact[0];
    case (w_band)
      2'd1:    begin w_mul_x = r_xm; w_mul_g = r_gact[1]; end
      2'd2:    begin w_mul_x = r_xa; w_mul_g = r_gact[2]; end
      default: ;
    endcase
  end

  // Full-precision product, floor-scaled back to Q format
  assign w_prod = ProdW'(w_mul_x) * ProdW'(w_mul_g);
  assign w_term = AccW'(w_prod >>> Presicion);

  // Clip the accumulated sum into the output range
  always_comb begin
    w_sat_val = Width'(r_acc);
    w_clip    = 1'b0;
    if (r_acc > AccMax) begin
      w_sat_val = OutMax;
      w_clip    = 1'b1;
    end else if (r_acc < AccMin) begin
      w_sat_val = OutMin;
      w_clip    = 1'b1;
    end
  end

  // Shadow gains: written any time, sel 3 is a no-op
  always_ff @(posedge clock44k or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) r_gsh[i] <= GainUnity;
    end else if (bus.gain_we) begin
      case (bus.gain_sel)
        2'd0:    r_gsh[0] <= bus.gain_data;
        2'd1:    r_gsh[1] <= bus.gain_data;
        2'd2:    r_gsh[2] <= bus.gain_data;
        default: ;
      endcase
    end
  end

  // Sample capture, active-gain snapshot (pre-write shadow) and accumulation
  always_ff @(posedge clock44k or negedge reset) begin
    if (!reset) begin
      r_xb  <= '0;
      r_xm  <= '0;
      r_xa  <= '0;
      r_acc <= '0;
      for (int i = 0; i < 3; i++) r_gact[i] <= GainUnity;
    end else if (w_capture) begin
      r_xb  <= bus.ykbajos;
      r_xm  <= bus.ykmedios;
      r_xa  <= bus.ykaltos;
      r_acc <= '0;
      for (int i = 0; i < 3; i++) r_gact[i] <= r_gsh[i];
    end else if (w_acc_en) begin
      r_acc <= r_acc + w_term;
    end
  end

  // Registered outputs
  always_ff @(posedge clock44k or negedge reset) begin
    if (!reset) begin
      r_yk       <= '0;
      r_yk_valid <= 1'b0;
      r_sat      <= 1'b0;
      r_drop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_yk_valid <= w_out_en;
      r_sat      <= w_out_en && w_clip;
      r_drop     <= w_drop;
      r_busy     <= (w_next != S_IDLE);
      if (w_out_en) r_yk <= w_sat_val;
    end
  end

  assign bus.yk       = r_yk;
  assign bus.yk_valid = r_yk_valid;
  assign bus.sat      = r_sat;
  assign bus.drop     = r_drop;
  assign bus.busy     = r_busy;

`ifdef ECUALIZADOR_PEAK_METER_EN
  logic [DecayLog-1:0] r_pk_cnt;
  logic [Width-2:0]    r_peak;
  logic [Width-2:0]    w_abs, w_pk_base, w_pk_next;

  // Magnitude of the new output, decay on counter wrap, then running max
  always_comb begin
    w_abs = (Width-1)'(w_sat_val);
    if (w_sat_val == OutMin)    w_abs = '1;
    else if (w_sat_val[Width-1]) w_abs = (Width-1)'(-w_sat_val);
    w_pk_base = (&r_pk_cnt) ? (r_peak - (r_peak >> 3)) : r_peak;
    w_pk_next = (w_abs > w_pk_base) ? w_abs : w_pk_base;
  end

  // Peak level and decay counter advance once per output sample
  always_ff @(posedge clock44k or negedge reset) begin
    if (!reset) begin
      r_pk_cnt <= '0;
      r_peak   <= '0;
    end else if (w_out_en) begin
      r_pk_cnt <= r_pk_cnt + DecayLog'(1);
      r_peak   <= w_pk_next;
    end
  end

  assign bus.peak = r_peak;
`else
  assign bus.peak = '0;
`endif

endmodule

// File: tb/tb_ecualizador_mezcla.sv
// Testbench for ecualizador_mezcla: directed cases plus randomized samples and
// gain writes, checked against an arithmetic reference model.
// Peak expectations follow ECUALIZADOR_PEAK_METER_EN when defined.
module tb_ecualizador_mezcla;

  localparam int unsigned W    = 25;
  localparam int unsigned P    = 16;
  localparam int unsigned DL   = 2;
  localparam longint      MAXV = (64'sd1 << (W - 1)) - 1;
  localparam longint      MINV = -(64'sd1 << (W - 1));
  localparam longint      UNIT = 64'sd1 << P;
`ifdef ECUALIZADOR_PEAK_METER_EN
  localparam bit PeakEn = 1'b1;
`else
  localparam bit PeakEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  longint sg [3];
  longint pk;
  longint nout;

  ecualizador_mezcla_if #(.Width(W)) bus ();

  ecualizador_mezcla #(.DecayLog(DL)) dut (
    .clock44k (clk),
    .reset    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Gain-weighted sum with floor scaling, clipped to the output range
  function automatic void ref_mix(input longint xb, xm, xa, gb, gm, ga,
                                  output longint y, output bit clip);
    longint s;
    s = ((xb * gb) >>> P) + ((xm * gm) >>> P) + ((xa * ga) >>> P);
    clip = 1'b0;
    y    = s;
    if (s > MAXV) begin y = MAXV; clip = 1'b1; end
    if (s < MINV) begin y = MINV; clip = 1'b1; end
  endfunction

  // Peak tracking: decay every 2^DL outputs, then running max of |y|
  function automatic void model_out(input longint y);
    longint a;
    nout++;
    a = (y < 0) ? -y : y;
    if (a > MAXV) a = MAXV;
    if (PeakEn) begin
      if (nout % (64'sd1 << DL) == 0) pk = pk - (pk >>> 3);
      if (a > pk) pk = a;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) sg[i] = UNIT;
    pk   = 0;
    nout = 0;
  endfunction

  task automatic write_gain(input logic [1:0] sel, input longint dat);
    @(negedge clk);
    bus.gain_we   = 1'b1;
    bus.gain_sel  = sel;
    bus.gain_data = W'(dat);
    if (sel != 2'd3) sg[sel] = dat;
    @(negedge clk);
    bus.gain_we = 1'b0;
  endtask

  // One accepted sample with optional gain write on the capture edge or mid-flight
  task automatic do_sample(input longint xb, xm, xa, input bit wcap, input bit wmid,
                           input logic [1:0] wsel, input longint wdat,
                           output longint y_obs);
    longint ag [3];
    longint ey;
    bit     eclip;
    @(negedge clk);
    check("valid_idle", bus.yk_valid, 0);
    bus.enable   = 1'b1;
    bus.ykbajos  = W'(xb);
    bus.ykmedios = W'(xm);
    bus.ykaltos  = W'(xa);
    for (int i = 0; i < 3; i++) ag[i] = sg[i];
    if (wcap) begin
      bus.gain_we   = 1'b1;
      bus.gain_sel  = wsel;
      bus.gain_data = W'(wdat);
      if (wsel != 2'd3) sg[wsel] = wdat;
    end
    ref_mix(xb, xm, xa, ag[0], ag[1], ag[2], ey, eclip);
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.gain_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("busy_valid", {bus.busy, bus.yk_valid}, 2'b10);
      if (k == 1 && wmid) begin
        bus.gain_we   = 1'b1;
        bus.gain_sel  = wsel;
        bus.gain_data = W'(wdat);
        if (wsel != 2'd3) sg[wsel] = wdat;
      end
      @(negedge clk);
      bus.gain_we = 1'b0;
    end
    model_out(ey);
    check("yk_valid", bus.yk_valid, 1);
    check("yk", bus.yk, ey);
    check("sat", bus.sat, eclip);
    check("busy_done", bus.busy, 0);
    check("peak", bus.peak, pk);
    y_obs = bus.yk;
  endtask

  initial begin
    longint y, ey, rx [3], g;
    bit     eclip;
    logic signed [W-1:0] t;
    logic [1:0] sel;

    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.ykbajos   = '0;
    bus.ykmedios  = '0;
    bus.ykaltos   = '0;
    bus.gain_we   = 1'b0;
    bus.gain_sel  = 2'd0;
    bus.gain_data = '0;
    repeat (3) @(negedge clk);
    check("rst_yk", bus.yk, 0);
    check("rst_valid", bus.yk_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_drop", bus.drop, 0);
    check("rst_peak", bus.peak, 0);
    rst_n = 1'b1;

    // Unity gains, low band only
    do_sample(1000, 0, 0, 0, 0, 2'd0, 0, y);
    check("low_unity", y, 1000);

    // Half gain on mid band, positive and negative (floor)
    write_gain(2'd1, 32768);
    do_sample(0, 1001, 0, 0, 0, 2'd0, 0, y);
    check("mid_half_pos", y, 500);
    do_sample(0, -1001, 0, 0, 0, 2'd0, 0, y);
    check("mid_half_neg", y, -501);

    // sel 3 ignored; restore unity and drive saturation both ways
    write_gain(2'd3, 12345);
    write_gain(2'd1, UNIT);
    do_sample(MAXV, MAXV, MAXV, 0, 0, 2'd0, 0, y);
    check("sat_pos", y, MAXV);
    check("sat_pos_flag", bus.sat, 1);
    do_sample(MINV, MINV, MINV, 0, 0, 2'd0, 0, y);
    check("sat_neg", y, MINV);
    check("sat_neg_flag", bus.sat, 1);

    // Reset in the middle of a computation
    write_gain(2'd0, 3 * UNIT / 4);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.ykbajos = 5000;
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", bus.busy, 0);
    check("midrst_yk", bus.yk, 0);
    check("midrst_valid", bus.yk_valid, 0);
    check("midrst_peak", bus.peak, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_no_valid", bus.yk_valid, 0);
    end

    // Peak sequence; also confirms gains came back to unity
    do_sample(8000, 0, 0, 0, 0, 2'd0, 0, y);
    check("post_rst_unity", y, 8000);
    check("peak_1", bus.peak, PeakEn ? 8000 : 0);
    do_sample(100, 0, 0, 0, 0, 2'd0, 0, y);
    do_sample(0, 100, 0, 0, 0, 2'd0, 0, y);
    check("peak_3", bus.peak, PeakEn ? 8000 : 0);
    do_sample(0, 0, 100, 0, 0, 2'd0, 0, y);
    check("peak_decay", bus.peak, PeakEn ? 7000 : 0);

    // Enable while busy is dropped; gain write then applies to the next sample
    @(negedge clk);
    bus.enable   = 1'b1;
    bus.ykbajos  = 300;
    bus.ykmedios = -200;
    bus.ykaltos  = 700;
    ref_mix(300, -200, 700, sg[0], sg[1], sg[2], ey, eclip);
    @(negedge clk);
    bus.enable = 1'b0;
    check("drop_idle", bus.drop, 0);
    @(negedge clk);
    bus.enable    = 1'b1;
    bus.ykbajos   = 12345;
    bus.gain_we   = 1'b1;
    bus.gain_sel  = 2'd2;
    bus.gain_data = W'(-UNIT);
    sg[2]         = -UNIT;
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.gain_we = 1'b0;
    check("drop_pulse", bus.drop, 1);
    @(negedge clk);
    check("drop_clear", bus.drop, 0);
    @(negedge clk);
    model_out(ey);
    check("drop_first_valid", bus.yk_valid, 1);
    check("drop_first_yk", bus.yk, 800);
    check("drop_first_model", bus.yk, ey);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("drop_no_second", bus.yk_valid, 0);
    end
    do_sample(0, 0, 1234, 0, 0, 2'd0, 0, y);
    check("gain_next_sample", y, -1234);

    // Randomized samples with gain writes on capture edges and mid-flight
    for (int i = 0; i < 200; i++) begin
      for (int b = 0; b < 3; b++) begin
        t     = W'($urandom);
        rx[b] = t;
      end
      g   = longint'($urandom_range(131072, 0)) - 65536;
      sel = 2'($urandom_range(3, 0));
      do_sample(rx[0], rx[1], rx[2], ($urandom_range(3, 0) == 0),
                ($urandom_range(3, 0) == 0), sel, g, y);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
